mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_starve_cnt.sv | 46 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-requester memory arbiter.
// Imported by arb_starve_cnt and mem_arbiter.
package mem_arb_pkg;

    localparam int AW_DEF         = 7;
    localparam int DW_DEF         = 32;
    localparam int LAT_DEF        = 2;
    localparam int STARVE_MAX_DEF = 4;

    // Widths sized for the largest legal LAT (7) and STARVE_MAX (15).
    localparam int WAIT_W   = 3;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive data-memory grants taken while instruction fetch waits.
// Once the count reaches STARVE_MAX, the next arbitration goes to fetch.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic idle,
    input  logic dm_grant,
    input  logic if_grant,
    input  logic if_pending,
    output logic starved
);

    localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // A dm grant with fetch idle falls through to the clear branch.
    always_comb begin
        cnt_d = cnt_q;
        if (if_grant) begin
            cnt_d = '0;
        end else if (dm_grant && if_pending) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (idle && !if_pending) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port
// memory, with one access in flight at a time and fetch-starvation protection.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int LAT        = LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [WAIT_W-1:0] LAT_M1 = WAIT_W'(LAT - 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                kill_q, kill_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d;
    logic [DW-1:0]       dm_rdata_q, dm_rdata_d;
    logic                dm_grant, if_grant;
    logic                starved;

    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .idle       (state_q == ST_IDLE),
        .dm_grant   (dm_grant),
        .if_grant   (if_grant),
        .if_pending (if_req),
        .starved    (starved)
    );

    // Request fields are captured only on grant, so later changes by the
    // requester cannot disturb an access already in flight.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        kill_d     = kill_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        dm_grant   = 1'b0;
        if_grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (dm_req && !(if_req && starved)) begin
                    dm_grant = 1'b1;
                    owner_d  = OWN_DM;
                    we_d     = dm_we;
                    addr_d   = dm_addr;
                    wdata_d  = dm_wdata;
                    state_d  = ST_ISSUE;
                end else if (if_req) begin
                    if_grant = 1'b1;
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (owner_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                wait_d  = LAT_M1;
                state_d = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (owner_q == OWN_IF && if_kill) begin
                    kill_d = 1'b1;
                end
                if (wait_q == '0) begin
                    if (owner_q == OWN_DM) begin
                        dm_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_RESP: begin
                kill_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_q     <= '0;
            kill_q     <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            kill_q     <= kill_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // A kill arriving in the response cycle itself must still hide the ack.
    assign if_ack    = (state_q == ST_RESP) && (owner_q == OWN_IF) && !kill_q && !if_kill;
    assign dm_ack    = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = (state_q == ST_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int AW   = 7;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam int MAXC = 40;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_kill = 1'b0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW         (AW),
        .DW         (DW),
        .LAT        (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory contents after reset; a few words are given memorable values.
    function automatic logic [DW-1:0] initWord(input int a);
        case (a)
            2:       return 32'hCAFE0002;
            5:       return 32'hDEADBEEF;
            default: return 32'hA5A50000 | 32'(a);
        endcase
    endfunction

    // Memory: data is valid only during the LAT-th cycle after the issue cycle.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            rd_ctr;
    logic [AW-1:0] rd_addr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ctr  <= 0;
            rd_addr <= '0;
            for (int i = 0; i < (1 << AW); i++) mem[i] <= initWord(i);
        end else begin
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) begin
                rd_ctr  <= 1;
                rd_addr <= mem_addr;
            end else if (rd_ctr != 0) begin
                rd_ctr <= (rd_ctr == LAT) ? 0 : rd_ctr + 1;
            end
        end
    end

    assign mem_rdata = (rd_ctr == LAT) ? mem[rd_addr] : (32'hBAD00000 | 32'(rd_ctr));

    // Reference model: phase counts cycles since grant (1 = issue, len = response).
    int            m_phase, m_len, m_starve;
    logic          m_own_dm, m_we, m_kill;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdexp, m_if_rd, m_dm_rd;
    logic          m_grant_dm, m_grant_if;

    assign m_grant_dm = (m_phase == 0) && dm_req && !(if_req && m_starve == SMAX);
    assign m_grant_if = (m_phase == 0) && !m_grant_dm && if_req;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase  <= 0;
            m_len    <= 0;
            m_starve <= 0;
            m_own_dm <= 1'b0;
            m_we     <= 1'b0;
            m_kill   <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdexp  <= '0;
            m_if_rd  <= '0;
            m_dm_rd  <= '0;
        end else if (m_phase == 0) begin
            if (m_grant_if) m_starve <= 0;
            else if (m_grant_dm && if_req) m_starve <= (m_starve == SMAX) ? SMAX : m_starve + 1;
            else if (!if_req) m_starve <= 0;
            if (m_grant_dm || m_grant_if) begin
                m_phase  <= 1;
                m_own_dm <= m_grant_dm;
                m_we     <= m_grant_dm && dm_we;
                m_addr   <= m_grant_dm ? dm_addr : if_addr;
                m_wdata  <= dm_wdata;
                m_len    <= (m_grant_dm && dm_we) ? 2 : LAT + 2;
                m_rdexp  <= mem[m_grant_dm ? dm_addr : if_addr];
            end
        end else begin
            if (!m_own_dm && if_kill) m_kill <= 1'b1;
            if (!m_we && m_phase == LAT + 1) begin
                if (m_own_dm) m_dm_rd <= m_rdexp;
                else m_if_rd <= m_rdexp;
            end
            if (m_phase == m_len) begin
                m_phase <= 0;
                m_kill  <= 1'b0;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("busy", 32'(busy), 32'(m_phase != 0));
        checkOutput("mem_en", 32'(mem_en), 32'(m_phase == 1));
        checkOutput("mem_we", 32'(mem_we), 32'(m_phase == 1 && m_we));
        checkOutput("if_ack", 32'(if_ack),
                    32'(m_phase != 0 && m_phase == m_len && !m_own_dm && !m_kill && !if_kill));
        checkOutput("dm_ack", 32'(dm_ack), 32'(m_phase != 0 && m_phase == m_len && m_own_dm));
        checkOutput("ack_overlap", 32'(if_ack && dm_ack), 32'd0);
        checkOutput("if_rdata", if_rdata, m_if_rd);
        checkOutput("dm_rdata", dm_rdata, m_dm_rd);
        if (m_phase == 1) checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_phase == 1 && m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
    end

    task automatic applyStimulus(input logic ifr, input logic [AW-1:0] ifa, input logic ifk,
                                 input logic dmr, input logic dmw, input logic [AW-1:0] dma,
                                 input logic [DW-1:0] dmd);
        if_req   = ifr;
        if_addr  = ifa;
        if_kill  = ifk;
        dm_req   = dmr;
        dm_we    = dmw;
        dm_addr  = dma;
        dm_wdata = dmd;
    endtask

    // One transaction; cycle 0 is the idle cycle in which the request is sampled.
    task automatic runTxn(input logic own_dm, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int kill_cyc, input int drop_cyc,
                          output int en_cyc, output int we_cyc, output int ack_cyc,
                          output int idle_cyc);
        en_cyc = -1; we_cyc = -1; ack_cyc = -1; idle_cyc = -1;
        @(posedge clk); #1;
        if (own_dm) applyStimulus(1'b0, '0, 1'b0, 1'b1, we, addr, wdata);
        else        applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        for (int k = 1; k <= MAXC && idle_cyc < 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if_addr  = 7'h7F;
                dm_addr  = 7'h7F;
                dm_wdata = 32'h0;
            end
            if_kill = (k == kill_cyc);
            if (k == drop_cyc || ack_cyc >= 0) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            @(negedge clk);
            if (mem_en && en_cyc < 0) en_cyc = k;
            if (mem_en && mem_we) we_cyc = k;
            if ((own_dm ? dm_ack : if_ack) && ack_cyc < 0) ack_cyc = k;
            if (!busy && k > 1) idle_cyc = k;
        end
        if_kill = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int en_c, we_c, ack_c, idle_c, n;
        int grants[6];
        int exp_order[6] = '{1, 1, 1, 1, 0, 1};

        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_dm_rdata", dm_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] dm read of 0x05");
        runTxn(1'b1, 1'b0, 7'h05, '0, -1, -1, en_c, we_c, ack_c, idle_c);
        checkOutput("rd05_en_cycle", 32'(en_c), 32'd1);
        checkOutput("rd05_ack_cycle", 32'(ack_c), 32'd4);
        checkOutput("rd05_idle_cycle", 32'(idle_c), 32'd5);
        checkOutput("rd05_data", dm_rdata, 32'hDEADBEEF);

        $display("[TB] dm write 0x10 then read back");
        runTxn(1'b1, 1'b1, 7'h10, 32'h12345678, -1, -1, en_c, we_c, ack_c, idle_c);
        checkOutput("wr10_en_cycle", 32'(en_c), 32'd1);
        checkOutput("wr10_we_cycle", 32'(we_c), 32'd1);
        checkOutput("wr10_ack_cycle", 32'(ack_c), 32'd2);
        checkOutput("wr10_rdata_kept", dm_rdata, 32'hDEADBEEF);
        runTxn(1'b1, 1'b0, 7'h10, '0, -1, -1, en_c, we_c, ack_c, idle_c);
        checkOutput("rd10_ack_cycle", 32'(ack_c), 32'd4);
        checkOutput("rd10_data", dm_rdata, 32'h12345678);

        $display("[TB] dm write with early req drop, then fetch of it");
        runTxn(1'b1, 1'b1, 7'h11, 32'h0BADF00D, -1, 1, en_c, we_c, ack_c, idle_c);
        checkOutput("wr11_ack_cycle", 32'(ack_c), 32'd2);
        runTxn(1'b0, 1'b0, 7'h11, '0, -1, -1, en_c, we_c, ack_c, idle_c);
        checkOutput("if11_ack_cycle", 32'(ack_c), 32'd4);
        checkOutput("if11_data", if_rdata, 32'h0BADF00D);

        $display("[TB] starvation: both requesters held");
        @(posedge clk); #1;
        applyStimulus(1'b1, 7'h03, 1'b0, 1'b1, 1'b0, 7'h04, '0);
        n = 0;
        for (int c = 0; c < 80 && n < 6; c++) begin
            @(negedge clk);
            if (mem_en) begin
                grants[n] = (mem_addr == 7'h03) ? 0 : 1;
                n++;
            end
        end
        @(posedge clk); #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        checkOutput("starve_grant_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("starve_grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        idle_c = -1;
        for (int c = 0; c < MAXC && idle_c < 0; c++) begin
            @(negedge clk);
            if (!busy) idle_c = c;
        end
        checkOutput("starve_drain", 32'(idle_c >= 0), 32'd1);

        $display("[TB] killed fetch of 0x02");
        runTxn(1'b0, 1'b0, 7'h02, '0, 2, 2, en_c, we_c, ack_c, idle_c);
        checkOutput("kill_ack_cycle", 32'(ack_c), 32'hFFFFFFFF);
        checkOutput("kill_idle_cycle", 32'(idle_c), 32'd5);
        checkOutput("kill_if_rdata", if_rdata, 32'hCAFE0002);

        $display("[TB] if_kill during dm read");
        runTxn(1'b1, 1'b0, 7'h04, '0, 2, -1, en_c, we_c, ack_c, idle_c);
        checkOutput("dmkill_ack_cycle", 32'(ack_c), 32'd4);
        checkOutput("dmkill_data", dm_rdata, 32'hA5A50004);

        $display("[TB] reset during wait of dm read");
        @(posedge clk); #1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 7'h05, '0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_dm_ack", 32'(dm_ack), 32'd0);
        checkOutput("midrst_dm_rdata", dm_rdata, 32'd0);
        dm_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        runTxn(1'b1, 1'b0, 7'h06, '0, -1, -1, en_c, we_c, ack_c, idle_c);
        checkOutput("postrst_ack_cycle", 32'(ack_c), 32'd4);
        checkOutput("postrst_data", dm_rdata, 32'hA5A50006);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
